// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: RAW forwarding selection, hazard stalls,
// branch flush sequencing, debug single-step hold and performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned FLUSH_CYC = 3,
  parameter int unsigned FWD_EN    = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              debug_en,
  input  logic              debug_step,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic              branch_id,
  input  logic [REG_AW-1:0] regw_addr_exe,
  input  logic              wb_wen_exe,
  input  logic              mem_ren_exe,
  input  logic [REG_AW-1:0] regw_addr_mem,
  input  logic              wb_wen_mem,
  input  logic              mem_ren_mem,
  output logic              if_rst,
  output logic              id_rst,
  output logic              exe_rst,
  output logic              mem_rst,
  output logic              wb_rst,
  output logic              if_en,
  output logic              id_en,
  output logic              exe_en,
  output logic              mem_en,
  output logic              wb_en,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  load_use_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Remaining flush cycles after the accepting cycle is FLUSH_CYC-1.
  localparam logic [1:0]       FcntLoad = 2'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

  logic [1:0] fcnt;
  logic       step_prev;
  logic       step_pulse, hold;
  logic       chk_a, chk_b;
  logic       hit_exe_a, hit_mem_a, hit_exe_b, hit_mem_b;
  logic       stall_a, stall_b, hazard_stall;
  logic       branch_acc, flush_act, flush_drv;

  // Register 0 is hardwired, so it never creates a dependency.
  assign chk_a     = rs_used & (rs_addr != '0);
  assign chk_b     = rt_used & (rt_addr != '0);
  assign hit_exe_a = chk_a & wb_wen_exe & (regw_addr_exe == rs_addr);
  assign hit_mem_a = chk_a & wb_wen_mem & (regw_addr_mem == rs_addr);
  assign hit_exe_b = chk_b & wb_wen_exe & (regw_addr_exe == rt_addr);
  assign hit_mem_b = chk_b & wb_wen_mem & (regw_addr_mem == rt_addr);

  // Operand A: forward select and stall; EXE result is the youngest and wins.
  always_comb begin
    fwd_a   = 2'd0;
    stall_a = 1'b0;
    if (!rst) begin
      if (FWD_EN != 0) begin
        if (hit_exe_a) begin
          if (mem_ren_exe) stall_a = 1'b1;
          else             fwd_a   = 2'd1;
        end else if (hit_mem_a) begin
          fwd_a = mem_ren_mem ? 2'd3 : 2'd2;
        end
      end else begin
        stall_a = hit_exe_a | hit_mem_a;
      end
    end
  end

  // Operand B: same rules as operand A, independent select.
  always_comb begin
    fwd_b   = 2'd0;
    stall_b = 1'b0;
    if (!rst) begin
      if (FWD_EN != 0) begin
        if (hit_exe_b) begin
          if (mem_ren_exe) stall_b = 1'b1;
          else             fwd_b   = 2'd1;
        end else if (hit_mem_b) begin
          fwd_b = mem_ren_mem ? 2'd3 : 2'd2;
        end
      end else begin
        stall_b = hit_exe_b | hit_mem_b;
      end
    end
  end

  assign hazard_stall = stall_a | stall_b;
  assign step_pulse   = debug_step & ~step_prev;
  assign hold         = debug_en & ~step_pulse;
  // A branch stuck behind a hazard stays in ID and is retried later.
  assign branch_acc   = branch_id & ~rst & ~hold & ~hazard_stall;
  assign flush_act    = branch_acc | (fcnt != 2'd0);
  assign flush_drv    = flush_act & ~rst & ~hold & ~hazard_stall;

  // Stage control, priority: reset > debug hold > hazard stall > branch flush.
  always_comb begin
    if_rst  = 1'b0;
    id_rst  = 1'b0;
    exe_rst = 1'b0;
    mem_rst = 1'b0;
    wb_rst  = 1'b0;
    if_en   = 1'b1;
    id_en   = 1'b1;
    exe_en  = 1'b1;
    mem_en  = 1'b1;
    wb_en   = 1'b1;
    if (rst) begin
      if_rst  = 1'b1;
      id_rst  = 1'b1;
      exe_rst = 1'b1;
      mem_rst = 1'b1;
      wb_rst  = 1'b1;
    end else if (hold) begin
      if_en  = 1'b0;
      id_en  = 1'b0;
      exe_en = 1'b0;
      mem_en = 1'b0;
      wb_en  = 1'b0;
    end else if (hazard_stall) begin
      if_en   = 1'b0;
      id_en   = 1'b0;
      exe_rst = 1'b1;
    end else if (flush_act) begin
      id_rst = 1'b1;
    end
  end

  // Flush sequencer and step edge detector; frozen by hold and hazard stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt      <= 2'd0;
      step_prev <= 1'b0;
    end else begin
      step_prev <= debug_step;
      if (branch_acc) begin
        fcnt <= FcntLoad;
      end else if ((fcnt != 2'd0) && !hold && !hazard_stall) begin
        fcnt <= fcnt - 2'd1;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_use_cnt <= '0;
      flush_cnt    <= '0;
    end else begin
      if (hazard_stall && !hold && (load_use_cnt != CntMax)) begin
        load_use_cnt <= load_use_cnt + 1'b1;
      end
      if (flush_drv && (flush_cnt != CntMax)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: three parameterisations driven by
// shared stimulus, checked against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, debug_en, debug_step, rs_used, rt_used, branch_id;
  logic       wb_wen_exe, mem_ren_exe, wb_wen_mem, mem_ren_mem;
  logic [4:0] rs_addr, rt_addr, regw_addr_exe, regw_addr_mem;

  // Packed control: {if,id,exe,mem,wb}_rst, {if,id,exe,mem,wb}_en, fwd_a, fwd_b
  logic [13:0] c0, c1, c2;
  logic [15:0] lu0, fl0, lu2, fl2;
  logic [2:0]  lu1, fl1;

  pipe_hazard_ctrl #(.REG_AW(5), .FLUSH_CYC(3), .FWD_EN(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
    .branch_id(branch_id), .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe),
    .mem_ren_exe(mem_ren_exe), .regw_addr_mem(regw_addr_mem), .wb_wen_mem(wb_wen_mem),
    .mem_ren_mem(mem_ren_mem),
    .if_rst(c0[13]), .id_rst(c0[12]), .exe_rst(c0[11]), .mem_rst(c0[10]), .wb_rst(c0[9]),
    .if_en(c0[8]), .id_en(c0[7]), .exe_en(c0[6]), .mem_en(c0[5]), .wb_en(c0[4]),
    .fwd_a(c0[3:2]), .fwd_b(c0[1:0]), .load_use_cnt(lu0), .flush_cnt(fl0)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .FLUSH_CYC(1), .FWD_EN(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
    .branch_id(branch_id), .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe),
    .mem_ren_exe(mem_ren_exe), .regw_addr_mem(regw_addr_mem), .wb_wen_mem(wb_wen_mem),
    .mem_ren_mem(mem_ren_mem),
    .if_rst(c1[13]), .id_rst(c1[12]), .exe_rst(c1[11]), .mem_rst(c1[10]), .wb_rst(c1[9]),
    .if_en(c1[8]), .id_en(c1[7]), .exe_en(c1[6]), .mem_en(c1[5]), .wb_en(c1[4]),
    .fwd_a(c1[3:2]), .fwd_b(c1[1:0]), .load_use_cnt(lu1), .flush_cnt(fl1)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .FLUSH_CYC(3), .FWD_EN(0), .CNT_W(16)) dut2 (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
    .branch_id(branch_id), .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe),
    .mem_ren_exe(mem_ren_exe), .regw_addr_mem(regw_addr_mem), .wb_wen_mem(wb_wen_mem),
    .mem_ren_mem(mem_ren_mem),
    .if_rst(c2[13]), .id_rst(c2[12]), .exe_rst(c2[11]), .mem_rst(c2[10]), .wb_rst(c2[9]),
    .if_en(c2[8]), .id_en(c2[7]), .exe_en(c2[6]), .mem_en(c2[5]), .wb_en(c2[4]),
    .fwd_a(c2[3:2]), .fwd_b(c2[1:0]), .load_use_cnt(lu2), .flush_cnt(fl2)
  );

  // Per-instance configuration seen by the model.
  int fc   [NI] = '{3, 1, 3};
  int fe   [NI] = '{1, 1, 0};
  int cmax [NI] = '{65535, 7, 65535};

  // Model state: flush cycles still owed, step history, counter values.
  int   m_left [NI];
  int   m_lu   [NI];
  int   m_fl   [NI];
  int   n_left [NI];
  int   n_lu   [NI];
  int   n_fl   [NI];
  logic m_prev;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [13:0] act_ctl(int k);
    if (k == 0) return c0;
    if (k == 1) return c1;
    return c2;
  endfunction

  function automatic int act_lu(int k);
    if (k == 0) return int'(lu0);
    if (k == 1) return int'(lu1);
    return int'(lu2);
  endfunction

  function automatic int act_fl(int k);
    if (k == 0) return int'(fl0);
    if (k == 1) return int'(fl1);
    return int'(fl2);
  endfunction

  // Returns {stall, fwd[1:0]} for one operand.
  function automatic logic [2:0] op_model(int fen, logic used, logic [4:0] addr);
    bit me, mm;
    me = used && addr != 0 && wb_wen_exe && addr == regw_addr_exe;
    mm = used && addr != 0 && wb_wen_mem && addr == regw_addr_mem;
    if (fen == 0) return {(me || mm) ? 1'b1 : 1'b0, 2'd0};
    if (me) return mem_ren_exe ? 3'b100 : 3'b001;
    if (mm) return mem_ren_mem ? 3'b011 : 3'b010;
    return 3'b000;
  endfunction

  task automatic chk(string nm, int k, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[inst %0d] t=%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Let inputs settle, compare every instance with the model, compute next state.
  task automatic settle_check();
    #1;
    for (int k = 0; k < NI; k++) begin
      logic [2:0]  oa, ob;
      logic [13:0] e;
      bit          hold, stall, acc, flush;
      oa    = op_model(fe[k], rs_used, rs_addr);
      ob    = op_model(fe[k], rt_used, rt_addr);
      hold  = debug_en && !(debug_step && !m_prev);
      stall = !rst && (oa[2] || ob[2]);
      acc   = branch_id && !rst && !hold && !stall;
      flush = acc || (m_left[k] != 0);
      e = {5'b00000, 5'b11111, rst ? 2'd0 : oa[1:0], rst ? 2'd0 : ob[1:0]};
      if (rst)        e[13:9] = 5'b11111;
      else if (hold)  e[8:4]  = 5'b00000;
      else if (stall) begin e[8] = 1'b0; e[7] = 1'b0; e[11] = 1'b1; end
      else if (flush) e[12] = 1'b1;
      chk("ctrl", k, int'(act_ctl(k)), int'(e));
      chk("load_use_cnt", k, act_lu(k), m_lu[k]);
      chk("flush_cnt", k, act_fl(k), m_fl[k]);
      if (rst) begin
        n_left[k] = 0; n_lu[k] = 0; n_fl[k] = 0;
      end else begin
        n_left[k] = m_left[k];
        if (acc) n_left[k] = fc[k] - 1;
        else if (m_left[k] > 0 && !hold && !stall) n_left[k] = m_left[k] - 1;
        n_lu[k] = (stall && !hold) ? ((m_lu[k] < cmax[k]) ? m_lu[k] + 1 : m_lu[k]) : m_lu[k];
        n_fl[k] = (flush && !hold && !stall) ?
                  ((m_fl[k] < cmax[k]) ? m_fl[k] + 1 : m_fl[k]) : m_fl[k];
      end
    end
  endtask

  task automatic advance();
    for (int k = 0; k < NI; k++) begin
      m_left[k] = n_left[k];
      m_lu[k]   = n_lu[k];
      m_fl[k]   = n_fl[k];
    end
    m_prev = rst ? 1'b0 : debug_step;
    @(negedge clk);
  endtask

  task automatic cyc();
    settle_check();
    advance();
  endtask

  task automatic clr();
    rst = 1'b0; debug_en = 1'b0; debug_step = 1'b0; branch_id = 1'b0;
    rs_used = 1'b0; rt_used = 1'b0; rs_addr = '0; rt_addr = '0;
    regw_addr_exe = '0; wb_wen_exe = 1'b0; mem_ren_exe = 1'b0;
    regw_addr_mem = '0; wb_wen_mem = 1'b0; mem_ren_mem = 1'b0;
  endtask

  task automatic do_reset();
    clr(); rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  typedef struct {
    logic [4:0] rs; logic rsu; logic [4:0] rt; logic rtu;
    logic [4:0] ae; logic we; logic le;
    logic [4:0] am; logic wm; logic lm;
    logic [1:0] efa; logic [1:0] efb; logic est; logic est_nf;
  } vec_t;

  vec_t vecs [10];
  int   ids, ids1, en_cnt;

  initial begin
    // rs rsu rt rtu | exe addr/wen/ld | mem addr/wen/ld | fwd_a fwd_b stall stall(no-fwd)
    vecs[0] = '{5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b1};
    vecs[1] = '{5'd0, 1'b0, 5'd4, 1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1};
    vecs[2] = '{5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 1'b1};
    vecs[3] = '{5'd0, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 2'd0, 2'd3, 1'b0, 1'b1};
    vecs[4] = '{5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 1'b1};
    vecs[5] = '{5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
    vecs[6] = '{5'd9, 1'b0, 5'd9, 1'b0, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
    vecs[7] = '{5'd8, 1'b1, 5'd9, 1'b1, 5'd8, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 2'd1, 2'd3, 1'b0, 1'b1};
    vecs[8] = '{5'd10, 1'b1, 5'd0, 1'b0, 5'd10, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 1'b1};
    vecs[9] = '{5'd11, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1};

    clr();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin m_left[k] = 0; m_lu[k] = 0; m_fl[k] = 0; end
    m_prev = 1'b0;

    // Reset state: all stage resets and enables high, selects zero.
    settle_check();
    chk("reset_ctrl", 0, int'(c0), int'(14'b11111_11111_00_00));
    advance();
    rst = 1'b0;

    // Table-driven forwarding / stall vectors.
    for (int i = 0; i < 10; i++) begin
      clr();
      rs_addr = vecs[i].rs; rs_used = vecs[i].rsu; rt_addr = vecs[i].rt; rt_used = vecs[i].rtu;
      regw_addr_exe = vecs[i].ae; wb_wen_exe = vecs[i].we; mem_ren_exe = vecs[i].le;
      regw_addr_mem = vecs[i].am; wb_wen_mem = vecs[i].wm; mem_ren_mem = vecs[i].lm;
      settle_check();
      chk($sformatf("vec%0d_fwd_a", i), 0, int'(c0[3:2]), int'(vecs[i].efa));
      chk($sformatf("vec%0d_fwd_b", i), 0, int'(c0[1:0]), int'(vecs[i].efb));
      chk($sformatf("vec%0d_stall", i), 0, int'(c0[11]), int'(vecs[i].est));
      chk($sformatf("vec%0d_stall_nofwd", i), 2, int'(c2[11]), int'(vecs[i].est_nf));
      chk($sformatf("vec%0d_fwd_a_nofwd", i), 2, int'(c2[3:2]), 0);
      advance();
    end

    // Load-use: LW r4 in EXE, ID reads rt=4, then the load moves to MEM.
    do_reset();
    rt_addr = 5'd4; rt_used = 1'b1;
    regw_addr_exe = 5'd4; wb_wen_exe = 1'b1; mem_ren_exe = 1'b1;
    settle_check();
    chk("lu_stall_ifid_en", 0, int'(c0[8:7]), 0);
    chk("lu_stall_exe_rst", 0, int'(c0[11]), 1);
    advance();
    regw_addr_exe = 5'd0; wb_wen_exe = 1'b0; mem_ren_exe = 1'b0;
    regw_addr_mem = 5'd4; wb_wen_mem = 1'b1; mem_ren_mem = 1'b1;
    settle_check();
    chk("lu_fwd_b", 0, int'(c0[1:0]), 3);
    chk("lu_count", 0, int'(lu0), 1);
    chk("lu_no_stall", 0, int'(c0[11]), 0);
    advance();

    // Branch flush length for FLUSH_CYC=3 (inst 0) and FLUSH_CYC=1 (inst 1).
    do_reset();
    ids = 0; ids1 = 0;
    for (int i = 0; i < 6; i++) begin
      branch_id = (i == 0);
      settle_check();
      ids  += int'(c0[12]);
      ids1 += int'(c1[12]);
      if (i < 3) chk("flush_consecutive", 0, int'(c0[12]), 1);
      advance();
    end
    chk("flush_len", 0, ids, 3);
    chk("flush_len", 1, ids1, 1);
    chk("flush_cnt_total", 0, int'(fl0), 3);
    chk("flush_cnt_total", 1, int'(fl1), 1);

    // Debug hold mid-flush, one step edge, then release.
    do_reset();
    branch_id = 1'b1; cyc(); branch_id = 1'b0;
    debug_en = 1'b1; en_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      debug_step = (i >= 3);
      settle_check();
      if (c0[8:4] == 5'b11111) en_cnt++;
      if (i < 3) chk("hold_id_rst", 0, int'(c0[12]), 0);
      if (i == 3) chk("step_flush_resume", 0, int'(c0[12]), 1);
      advance();
    end
    chk("step_en_cycles", 0, en_cnt, 1);
    debug_en = 1'b0; debug_step = 1'b0;
    settle_check();
    chk("post_debug_flush", 0, int'(c0[12]), 1);
    advance();
    settle_check();
    chk("post_debug_done", 0, int'(c0[12]), 0);
    advance();
    chk("debug_flush_cnt", 0, int'(fl0), 3);

    // Reset in the 2nd cycle of a flush abandons it.
    do_reset();
    branch_id = 1'b1; cyc(); branch_id = 1'b0;
    rst = 1'b1; cyc(); rst = 1'b0;
    settle_check();
    chk("rst_abandon_id_rst", 0, int'(c0[12]), 0);
    chk("rst_abandon_lu", 0, int'(lu0), 0);
    chk("rst_abandon_fl", 0, int'(fl0), 0);
    advance();

    // Randomized traffic against the model (also saturates the 3-bit counters).
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) debug_en = ~debug_en;
      debug_step    = 1'($urandom_range(0, 1));
      branch_id     = ($urandom_range(0, 5) == 0);
      rs_used       = 1'($urandom_range(0, 1));
      rt_used       = 1'($urandom_range(0, 1));
      rs_addr       = 5'($urandom_range(0, 3));
      rt_addr       = 5'($urandom_range(0, 3));
      regw_addr_exe = 5'($urandom_range(0, 3));
      regw_addr_mem = 5'($urandom_range(0, 3));
      wb_wen_exe    = ($urandom_range(0, 2) == 0);
      mem_ren_exe   = 1'($urandom_range(0, 1));
      wb_wen_mem    = ($urandom_range(0, 2) == 0);
      mem_ren_mem   = 1'($urandom_range(0, 1));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- REG_AW, 5: register address width.
- FLUSH_CYC, 3: ID flush cycles per branch/jump; legal range 1..3.
- FWD_EN, 1: 1 = forwarding enabled; 0 = stall on every RAW hazard.
- CNT_W, 16: width of the performance counters.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst, in, 1: reset, synchronous, active-high.
- debug_en, in, 1: debug suspend mode.
- debug_step, in, 1: step request; each rising edge allows one pipeline advance.
- rs_addr, in, REG_AW: ID source register A.
- rt_addr, in, REG_AW: ID source register B.
- rs_used, in, 1: ID instruction reads rs.
- rt_used, in, 1: ID instruction reads rt.
- branch_id, in, 1: ID instruction redirects the PC (pc_src not next).
- regw_addr_exe, in, REG_AW: EXE-stage destination register.
- wb_wen_exe, in, 1: EXE-stage register write enable.
- mem_ren_exe, in, 1: EXE-stage instruction is a load.
- regw_addr_mem, in, REG_AW: MEM-stage destination register.
- wb_wen_mem, in, 1: MEM-stage register write enable.
- mem_ren_mem, in, 1: MEM-stage instruction is a load.
- if_rst, id_rst, exe_rst, mem_rst, wb_rst, out, 1 each: stage reset.
- if_en, id_en, exe_en, mem_en, wb_en, out, 1 each: stage enable.
- fwd_a, out, 2: operand A forward select.
- fwd_b, out, 2: operand B forward select.
- load_use_cnt, out, CNT_W: count of load-use / RAW stall cycles.
- flush_cnt, out, CNT_W: count of branch flush cycles.

Function
REQ-003 Forward encoding: 0 = register file, 1 = EXE ALU result, 2 = MEM ALU result, 3 = MEM load data.

REQ-004 Operand A hazard check applies only when rs_used=1 and rs_addr≠0. Operand B uses the same rules with rt_used and rt_addr, and drives fwd_b independently.

REQ-005 Operand A with FWD_EN=1:
- EXE match (regw_addr_exe==rs_addr and wb_wen_exe): if mem_ren_exe=1, raise hazard stall with fwd_a=0; otherwise fwd_a=1.
- Else MEM match: fwd_a=3 if mem_ren_mem=1, else 2.
- EXE match takes priority over MEM match.

REQ-006 With FWD_EN=0, any EXE or MEM match on either operand raises hazard stall, and fwd_a=fwd_b=0.

REQ-007 The hazard stall is the OR of the operand A and operand B stall conditions.

REQ-008 step_pulse = debug_step & ~step_prev, where step_prev is debug_step registered each clk. hold = debug_en & ~step_pulse.

REQ-009 Stage control is combinational. Defaults: all rst=0, all en=1. Priority, highest first:
- rst: all five *_rst=1.
- hold: all five *_en=0.
- hazard stall: if_en=0, id_en=0, exe_rst=1.
- branch flush: id_rst=1.

REQ-010 A branch is accepted when branch_id=1, rst=0, hold=0 and there is no hazard stall. A branch blocked by a hazard stall waits in ID and is not accepted.

REQ-011 Flush counter fcnt (2 bits):
- On the accepted cycle: load FLUSH_CYC-1.
- Otherwise, when fcnt≠0 and hold=0: decrement by 1.
- When hold=1: freeze.

REQ-012 Branch flush is active when (branch accepted) or fcnt≠0. The id_rst flush therefore lasts exactly FLUSH_CYC unheld cycles per branch.

REQ-013 A hazard stall during fcnt≠0 takes priority for that cycle and fcnt freezes. The flush resumes when the stall clears.

REQ-014 load_use_cnt increments by 1 on every cycle with hazard stall and rst=0 and hold=0. flush_cnt increments on every cycle where REQ-009 drives id_rst from branch flush. Both counters saturate at 2^CNT_W-1 and never wrap.

REQ-015 fwd_a and fwd_b are combinational and independent of hold. They are 0 while rst=1.

Reset
REQ-016 On a clk edge with rst=1: fcnt=0, step_prev=0, load_use_cnt=0, flush_cnt=0.

REQ-017 Reset asserted mid-flush or mid-stall abandons the operation. The first cycle after reset has no flush pending.

REQ-018 While rst=1, all *_rst=1 and all *_en=1, regardless of debug_en.

Verification
REQ-019 ADD r3 in EXE (wb_wen_exe=1, mem_ren_exe=0), ID reads rs=3 → fwd_a=1, no stall, exe_rst=0.

REQ-020 LW r4 in EXE, ID reads rt=4 → if_en=id_en=0, exe_rst=1 for 1 cycle. Next cycle LW is in MEM → fwd_b=3, load_use_cnt=1.

REQ-021 FLUSH_CYC=3, branch_id pulsed 1 cycle → id_rst=1 for exactly 3 consecutive cycles, flush_cnt=3. Repeat with FLUSH_CYC=1 → 1 cycle, flush_cnt=1.

REQ-022 FWD_EN=0, r5 written in MEM (non-load), ID reads rs=5 → stall asserted, fwd_a=0. Address 0 match → no stall.

REQ-023 debug_en=1 with debug_step held low → all en=0 and fcnt frozen. One 0→1 step edge → exactly one cycle with en=1.

REQ-024 rst asserted at 2nd cycle of a 3-cycle flush → next cycle id_rst=0 and both counters read 0.
